decode: RTL and testbench

Instruction decode stage of the rv32i pipeline, directly downstream of the fetch stage. Each cycle it accepts the instruction word and its PC from fetch, then cracks the fields and generates the sign-extended immediate. Results are registered into the decode/execute pipeline register. It also detects load-use hazards and back-pressures fetch through the pipeline control handshake, inserting a bubble toward execute.

---
 rtl/decode_if.sv | 36 +++
 rtl/decode.sv | 170 +++++++++++++++++
 tb/tb_decode.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_if.sv
// Fetch-to-decode and decode-to-execute signal bundle for the decode stage.
// master = fetch/execute side, slave = decode stage.
interface decode_if;
    logic [31:0] inst_in;
    logic [31:0] pc_in;
    logic        valid_in;
    logic        stall_in;
    logic        flush_in;
    logic        decode_pipeline_ctl_out;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        is_load;
    logic        illegal;

    modport master (
        output inst_in, pc_in, valid_in, stall_in, flush_in,
        input  decode_pipeline_ctl_out, valid_out, pc_out, inst_out,
        input  opcode, rd, rs1, rs2, funct3, funct7, imm,
        input  is_load, illegal
    );

    modport slave (
        input  inst_in, pc_in, valid_in, stall_in, flush_in,
        output decode_pipeline_ctl_out, valid_out, pc_out, inst_out,
        output opcode, rd, rs1, rs2, funct3, funct7, imm,
        output is_load, illegal
    );
endinterface

// File: rtl/decode.sv
// rv32i decode stage: field crack, immediate gen, load-use bubble.
// Define DECODE_ILLEGAL_TRAP_EN to pass unknown opcodes on flagged illegal.
module decode #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic     clk,
    input  logic     rst,
    decode_if.slave  bus
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        is_load;
        logic        illegal;
    } fields_t;

    function automatic fields_t crack(input logic [31:0] w);
        fields_t f;
        f.opcode  = w[6:0];
        f.rd      = w[11:7];
        f.rs1     = w[19:15];
        f.rs2     = w[24:20];
        f.funct3  = w[14:12];
        f.funct7  = w[31:25];
        f.imm     = '0;
        f.is_load = 1'b0;
        f.illegal = 1'b0;
        unique case (1'b1)
            (w[6:0] == OP_LUI) || (w[6:0] == OP_AUIPC): begin
                f.rs1 = '0;
                f.rs2 = '0;
                f.imm = {w[31:12], 12'h000};
            end
            w[6:0] == OP_JAL: begin
                f.rs1 = '0;
                f.rs2 = '0;
                f.imm = {{12{w[31]}}, w[19:12], w[20],
                         w[30:21], 1'b0};
            end
            (w[6:0] == OP_JALR) || (w[6:0] == OP_IMM) ||
            (w[6:0] == OP_SYSTEM): begin
                f.rs2 = '0;
                f.imm = {{20{w[31]}}, w[31:20]};
            end
            w[6:0] == OP_LOAD: begin
                f.rs2     = '0;
                f.imm     = {{20{w[31]}}, w[31:20]};
                f.is_load = 1'b1;
            end
            w[6:0] == OP_MISC: begin
                f.rs2 = '0;
            end
            w[6:0] == OP_STORE: begin
                f.rd  = '0;
                f.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            w[6:0] == OP_BRANCH: begin
                f.rd  = '0;
                f.imm = {{19{w[31]}}, w[31], w[7], w[30:25],
                         w[11:8], 1'b0};
            end
            w[6:0] == OP_OP: ;
            default: f.illegal = 1'b1;
        endcase
        return f;
    endfunction

    // {uses_rs1, uses_rs2}
    function automatic logic [1:0] uses(input logic [31:0] w);
        logic [1:0] u;
        u = 2'b00;
        unique case (1'b1)
            (w[6:0] == OP_OP) || (w[6:0] == OP_STORE) ||
            (w[6:0] == OP_BRANCH): u = 2'b11;
            (w[6:0] == OP_IMM) || (w[6:0] == OP_LOAD) ||
            (w[6:0] == OP_JALR) || (w[6:0] == OP_SYSTEM): u = 2'b10;
            default: u = 2'b00;
        endcase
        return u;
    endfunction

    localparam fields_t NOP_F = crack(NOP_INST);

    logic            valid_r;
    logic [XLEN-1:0] pc_r;
    logic [31:0]     inst_r;
    fields_t         f_r;

    fields_t     src_f;
    fields_t     cap_f;
    logic [31:0] cap_inst;
    logic        take;
    logic [1:0]  use_src;
    logic        hazard;

    always_comb begin
        src_f = crack(bus.inst_in);
`ifdef DECODE_ILLEGAL_TRAP_EN
        take = bus.valid_in;
`else
        take = bus.valid_in & ~src_f.illegal;
`endif
        cap_f    = take ? src_f : NOP_F;
        cap_inst = take ? bus.inst_in : NOP_INST;
    end

    always_comb begin
        use_src = uses(bus.inst_in);
        hazard  = valid_r & f_r.is_load & (f_r.rd != 5'd0) &
                  bus.valid_in &
                  ((use_src[1] & (bus.inst_in[19:15] == f_r.rd)) |
                   (use_src[0] & (bus.inst_in[24:20] == f_r.rd)));
    end

    assign bus.decode_pipeline_ctl_out =
        bus.flush_in | (~bus.stall_in & ~hazard);

    // Flush beats stall; a stalled hazard waits for the first free edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= 1'b0;
            pc_r    <= '0;
            inst_r  <= NOP_INST;
            f_r     <= NOP_F;
        end else if (bus.flush_in | (~bus.stall_in & hazard)) begin
            valid_r <= 1'b0;
            pc_r    <= '0;
            inst_r  <= NOP_INST;
            f_r     <= NOP_F;
        end else if (!bus.stall_in) begin
            valid_r <= take;
            pc_r    <= bus.pc_in;
            inst_r  <= cap_inst;
            f_r     <= cap_f;
        end
    end

    assign bus.valid_out = valid_r;
    assign bus.pc_out    = pc_r;
    assign bus.inst_out  = inst_r;
    assign bus.opcode    = f_r.opcode;
    assign bus.rd        = f_r.rd;
    assign bus.rs1       = f_r.rs1;
    assign bus.rs2       = f_r.rs2;
    assign bus.funct3    = f_r.funct3;
    assign bus.funct7    = f_r.funct7;
    assign bus.imm       = f_r.imm;
    assign bus.is_load   = f_r.is_load;
    assign bus.illegal   = f_r.illegal;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for the decode stage: driver pushes model
// expectations, a negedge monitor pops and compares.
module tb_decode;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    decode_if bus ();

    decode dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum {FU, FJ, FI, FM, FS, FB, FR, FX} fmt_e;

    typedef struct {
        bit          v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        bit          ld;
        bit          ill;
    } st_t;

    typedef struct {
        st_t s;
        bit  ctl;
    } exp_t;

    exp_t q[$];
    st_t  m;
    int   total = 0;
    int   bad = 0;

    function automatic fmt_e fmt_of(input logic [31:0] w);
        case (w[6:0])
            7'b0110111, 7'b0010111: return FU;
            7'b1101111: return FJ;
            7'b1100111, 7'b0010011,
            7'b1110011, 7'b0000011: return FI;
            7'b0001111: return FM;
            7'b0100011: return FS;
            7'b1100011: return FB;
            7'b0110011: return FR;
            default: return FX;
        endcase
    endfunction

    function automatic st_t model_of(input logic [31:0] w,
                                     input logic [31:0] pc,
                                     input bit v);
        st_t  s;
        fmt_e f;
        f = fmt_of(w);
        if (!v || (f == FX && !TRAP)) begin
            w = NOP;
            v = 1'b0;
            f = FI;
        end
        s.v    = v;
        s.pc   = pc;
        s.inst = w;
        s.op   = w[6:0];
        s.rd   = (f == FS || f == FB) ? 5'd0 : w[11:7];
        s.rs1  = (f == FU || f == FJ) ? 5'd0 : w[19:15];
        s.rs2  = (f == FI || f == FU || f == FJ || f == FM)
                 ? 5'd0 : w[24:20];
        s.f3   = w[14:12];
        s.f7   = w[31:25];
        s.ld   = (w[6:0] == 7'd3);
        s.ill  = (f == FX);
        case (f)
            FI: s.imm = 32'($signed(w) >>> 20);
            FS: s.imm = (32'($signed(w) >>> 25) << 5) | 32'(w[11:7]);
            FB: s.imm = (32'($signed(w) >>> 31) << 12)
                      | (32'(w[7]) << 11) | (32'(w[30:25]) << 5)
                      | (32'(w[11:8]) << 1);
            FJ: s.imm = (32'($signed(w) >>> 31) << 20)
                      | (32'(w[19:12]) << 12) | (32'(w[20]) << 11)
                      | (32'(w[30:21]) << 1);
            FU: s.imm = w & 32'hFFFFF000;
            default: s.imm = 32'd0;
        endcase
        return s;
    endfunction

    function automatic logic [1:0] reads(input logic [31:0] w);
        fmt_e f;
        f = fmt_of(w);
        if (f == FR || f == FS || f == FB) return 2'b11;
        if (f == FI) return 2'b10;
        return 2'b00;
    endfunction

    task automatic step(input logic [31:0] w, input logic [31:0] pc,
                        input bit v, input bit st, input bit fl,
                        input bit r, output bit c);
        logic [1:0] u;
        bit         haz;
        @(posedge clk);
        #1;
        rst          = r;
        bus.inst_in  = w;
        bus.pc_in    = pc;
        bus.valid_in = v;
        bus.stall_in = st;
        bus.flush_in = fl;
        if (!r) m = model_of(NOP, 32'd0, 1'b0);
        u   = reads(w);
        haz = m.v && m.ld && (m.rd != 0) && v &&
              ((u[1] && w[19:15] == m.rd) ||
               (u[0] && w[24:20] == m.rd));
        c = fl || (!st && !haz);
        q.push_back('{s: m, ctl: c});
        if (r) begin
            if (fl || (!st && haz)) m = model_of(NOP, 32'd0, 1'b0);
            else if (!st) m = model_of(w, pc, v);
        end
    endtask

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ctl", 32'(bus.decode_pipeline_ctl_out), 32'(e.ctl));
            chk("valid", 32'(bus.valid_out), 32'(e.s.v));
            chk("pc", bus.pc_out, e.s.pc);
            chk("inst", bus.inst_out, e.s.inst);
            chk("opcode", 32'(bus.opcode), 32'(e.s.op));
            chk("rd", 32'(bus.rd), 32'(e.s.rd));
            chk("rs1", 32'(bus.rs1), 32'(e.s.rs1));
            chk("rs2", 32'(bus.rs2), 32'(e.s.rs2));
            chk("funct3", 32'(bus.funct3), 32'(e.s.f3));
            chk("funct7", 32'(bus.funct7), 32'(e.s.f7));
            chk("imm", bus.imm, e.s.imm);
            chk("is_load", 32'(bus.is_load), 32'(e.s.ld));
            chk("illegal", 32'(bus.illegal), 32'(e.s.ill));
        end
    end

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [11];
        logic [31:0] w;
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                7'b0110011, 7'b0001111, 7'b1110011};
        w = $urandom();
        if ($urandom_range(0, 11) == 0) return w;
        w[6:0]   = ops[$urandom_range(0, 10)];
        if ($urandom_range(0, 2) == 0) w[6:0] = 7'b0000011;
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        bit          c;
        bit          v;
        logic [31:0] w;
        logic [31:0] pc;
        bus.inst_in  = NOP;
        bus.pc_in    = '0;
        bus.valid_in = 1'b0;
        bus.stall_in = 1'b0;
        bus.flush_in = 1'b0;
        m = model_of(NOP, 32'd0, 1'b0);

        for (int i = 0; i < 4; i++)
            step($urandom(), $urandom(), 1'($urandom()),
                 1'($urandom()), 1'($urandom()), 1'b0, c);

        step(32'h00500093, 32'h0, 1, 0, 0, 1, c);
        step(32'hFE208EE3, 32'h4, 1, 0, 0, 1, c);
        step(32'h123451B7, 32'h8, 1, 0, 0, 1, c);
        // load-use: one bubble, add re-presented while ctl is low
        step(32'h00812283, 32'hC, 1, 0, 0, 1, c);
        step(32'h00128333, 32'h10, 1, 0, 0, 1, c);
        step(32'h00128333, 32'h10, 1, 0, 0, 1, c);
        step(32'h00812003, 32'h14, 1, 0, 0, 1, c);
        step(32'h00100333, 32'h18, 1, 0, 0, 1, c);
        // stall three cycles with a new word waiting
        for (int i = 0; i < 3; i++)
            step(32'h00500093, 32'h1C, 1, 1, 0, 1, c);
        step(32'h00500093, 32'h1C, 1, 0, 0, 1, c);
        // stall overlapping a load-use
        step(32'h00812283, 32'h20, 1, 0, 0, 1, c);
        step(32'h00128333, 32'h24, 1, 1, 0, 1, c);
        step(32'h00128333, 32'h24, 1, 1, 0, 1, c);
        step(32'h00128333, 32'h24, 1, 0, 0, 1, c);
        step(32'h00128333, 32'h24, 1, 0, 0, 1, c);
        // flush with stall while a valid add is held
        step(32'h00128333, 32'h28, 1, 0, 0, 1, c);
        step(32'h00128333, 32'h2C, 1, 1, 1, 1, c);
        step(32'hFFFFFFFF, 32'h30, 1, 0, 0, 1, c);
        step(32'h00000000, 32'h34, 1, 0, 0, 1, c);
        step(32'h00500093, 32'h38, 0, 0, 0, 1, c);
        // reset during a stall and during a pending hazard
        step(32'h00812283, 32'h3C, 1, 0, 0, 1, c);
        step(32'h00128333, 32'h40, 1, 1, 0, 1, c);
        step(32'h00128333, 32'h40, 1, 1, 0, 0, c);
        step(32'h00128333, 32'h40, 1, 0, 0, 1, c);

        c = 1'b1;
        v = 1'b1;
        w = NOP;
        pc = '0;
        for (int i = 0; i < 400; i++) begin
            if (c) begin
                w  = rand_inst();
                pc = $urandom() & 32'hFFFFFFFC;
                v  = ($urandom_range(0, 7) != 0);
            end
            step(w, pc, v, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 99) != 0, c);
        end

        step(NOP, 32'h0, 0, 0, 0, 1, c);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
